ofm_drain: RTL and testbench

// Output-side drain stage directly downstream of the bottom PE of one systolic column.

---
 rtl/ofm_drain.sv | 140 ++++++++++++++
 tb/tb_ofm_drain.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_drain.sv
// Output drain for one systolic column: requantizes the partial-sum stream
// (round half-up, arithmetic shift, saturate) and buffers it in a small FWFT FIFO.
module ofm_drain #(
  parameter int OWIDTH = 24,
  parameter int QWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int SWIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_o,
  input  logic [OWIDTH-1:0]          ofm,
  input  logic [SWIDTH-1:0]          shift,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [QWIDTH-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [OWIDTH:0] ONE =
    {{OWIDTH{1'b0}}, 1'b1};
  localparam logic signed [OWIDTH:0] QMAX =
    {{(OWIDTH-QWIDTH+2){1'b0}}, {(QWIDTH-1){1'b1}}};
  localparam logic signed [OWIDTH:0] QMIN =
    {{(OWIDTH-QWIDTH+2){1'b1}}, {(QWIDTH-1){1'b0}}};

  logic                     s1_v;
  logic signed [OWIDTH:0]   s1_r;
  logic [SWIDTH-1:0]        s1_sh;
  logic                     s2_v;
  logic [QWIDTH-1:0]        s2_q;

  logic [OWIDTH:0]          rnd;
  logic [OWIDTH:0]          sum_r;
  logic signed [OWIDTH:0]   shq;
  logic signed [OWIDTH:0]   sat;

  logic [QWIDTH-1:0]        mem [DEPTH];
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            rptr;
  logic                     full;
  logic                     pop;
  logic                     push;
  logic                     drop;

  // Add the half-LSB rounding bias to the sign-extended sample.
  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = ONE << (shift - 1'b1);
    end
    sum_r = {ofm[OWIDTH-1], ofm} + rnd;
  end

  // Arithmetic shift of the biased sum, then clamp into the output range.
  always_comb begin
    shq = s1_r >>> s1_sh;
    sat = shq;
    if (shq > QMAX) begin
      sat = QMAX;
    end else if (shq < QMIN) begin
      sat = QMIN;
    end
  end

  // Stage 1: capture biased sum and the shift that goes with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_r  <= '0;
      s1_sh <= '0;
    end else begin
      s1_v <= en_o & ~flush;
      if (en_o) begin
        s1_r  <= sum_r;
        s1_sh <= shift;
      end
    end
  end

  // Stage 2: hold the saturated result for the FIFO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_q <= '0;
    end else begin
      s2_v <= s1_v & ~flush;
      if (s1_v) begin
        s2_q <= sat[QWIDTH-1:0];
      end
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];
  assign pop       = out_valid & out_ready;
  assign push      = s2_v & (~full | pop);
  assign drop      = s2_v & full & ~pop;

  // FIFO storage, pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= s2_q;
        wptr      <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ofm_drain.sv
// Bench for ofm_drain: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_ofm_drain;

  localparam int OW = 24;
  localparam int QW = 8;
  localparam int D  = 4;
  localparam int SW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_o = 1'b0;
  logic [OW-1:0] ofm = '0;
  logic [SW-1:0] shift = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [QW-1:0] out_data;
  logic [CW-1:0] count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int val;
    int due;
  } pend_t;

  pend_t pend[$];
  int    fq[$];
  bit    ovf_m = 1'b0;
  int    edge_n = 0;

  ofm_drain #(.OWIDTH(OW), .QWIDTH(QW), .DEPTH(D), .SWIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .en_o(en_o), .ofm(ofm),
    .shift(shift), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic int quant(int v, int sh);
    longint x;
    longint p;
    p = longint'(1) << sh;
    x = longint'(v);
    if (sh > 0) x = x + p / 2;
    // floor division by 2^sh
    if (x >= 0) x = x / p;
    else x = -((-x + p - 1) / p);
    if (x > 127) x = 127;
    if (x < -128) x = -128;
    return int'(x);
  endfunction

  task automatic model_clear();
    pend.delete();
    fq.delete();
    ovf_m = 1'b0;
  endtask

  task automatic cycle();
    bit    pop;
    bit    full;
    pend_t p;
    @(posedge clk);
    if (!rst_n || flush) begin
      model_clear();
    end else begin
      pop  = (fq.size() > 0) && out_ready;
      full = (fq.size() == D);
      if (pop) void'(fq.pop_front());
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        p = pend.pop_front();
        if (!full || pop) fq.push_back(p.val);
        else ovf_m = 1'b1;
      end
      if (en_o) begin
        p.val = quant(int'($signed(ofm)), int'(shift));
        p.due = edge_n + 2;
        pend.push_back(p);
      end
    end
    edge_n++;
    #1;
  endtask

  task automatic drive(input bit e, input int v, input int sh);
    en_o  = e;
    ofm   = v[OW-1:0];
    shift = sh[SW-1:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0d exp 0", out_valid);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", count);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow got %0d exp 0", overflow);
    end
    checks++;
    if (out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_data got %0d exp 0", out_data);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1, 5, 0);
    cycle();
    drive(1, -7, 0);
    cycle();
    drive(0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got %0d exp 0", out_valid);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 8'sd5) begin
      errors++;
      $display("FAIL basic_first got v%0d d%0d exp v1 d5",
               out_valid, $signed(out_data));
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== -8'sd7) begin
      errors++;
      $display("FAIL basic_second got v%0d d%0d exp v1 d-7",
               out_valid, $signed(out_data));
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty got %0d exp 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    int smp[2];
    int exq[2];
    int k;
    smp = '{300, -300};
    exq = '{127, -128};
    k = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 2) drive(1, smp[i], 0);
      else drive(0, 0, 0);
      cycle();
      if (out_valid === 1'b1) begin
        checks++;
        if (k >= 2 || int'($signed(out_data)) !== exq[k]) begin
          errors++;
          $display("FAIL sat_data[%0d] got %0d exp %0d",
                   k, $signed(out_data), (k < 2) ? exq[k] : 0);
        end
        k++;
      end
    end
    checks++;
    if (k !== 2) begin
      errors++;
      $display("FAIL sat_nout got %0d exp 2", k);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_overflow got %0d exp 0", overflow);
    end
  endtask

  task automatic test_rounding();
    int smp[4];
    int exq[4];
    int k;
    smp = '{24, -24, 8, -9};
    exq = '{2, -1, 1, -1};
    k = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) drive(1, smp[i], 4);
      else drive(0, 0, 0);
      cycle();
      if (out_valid === 1'b1) begin
        checks++;
        if (k >= 4 || int'($signed(out_data)) !== exq[k]) begin
          errors++;
          $display("FAIL round_data[%0d] got %0d exp %0d",
                   k, $signed(out_data), (k < 4) ? exq[k] : 0);
        end
        k++;
      end
    end
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL round_nout got %0d exp 4", k);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive(1, i, 0);
      cycle();
    end
    drive(0, 0, 0);
    repeat (3) cycle();
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_count got %0d exp 4", count);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %0d exp 1", overflow);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || int'($signed(out_data)) !== i) begin
        errors++;
        $display("FAIL ovf_order[%0d] got v%0d d%0d exp v1 d%0d",
                 i, out_valid, $signed(out_data), i);
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after got v%0d o%0d exp v0 o1",
               out_valid, overflow);
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flush got %0d exp 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    int v;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 4000)) - 2000;
      drive(1, v, int'($urandom_range(0, 5)));
      cycle();
    end
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL b2b_fill got %0d exp 4", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 4000)) - 2000;
      drive(1, v, int'($urandom_range(0, 5)));
      cycle();
      checks++;
      if (count !== 3'd4 || fq.size() == 0 ||
          int'($signed(out_data)) !== fq[0]) begin
        errors++;
        $display("FAIL b2b_step[%0d] got c%0d d%0d exp c4 d%0d",
                 i, count, $signed(out_data),
                 (fq.size() > 0) ? fq[0] : 0);
      end
    end
    drive(0, 0, 0);
    repeat (8) cycle();
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got o%0d v%0d exp o0 v0",
               overflow, out_valid);
    end
  endtask

  task automatic test_flush_reset();
    bit seen;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1, i + 20, 0);
      cycle();
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL fl_pre got %0d exp 1", overflow);
    end
    flush = 1'b1;
    drive(1, 99, 0);
    cycle();
    flush = 1'b0;
    drive(0, 0, 0);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fl_clear got c%0d v%0d o%0d exp c0 v0 o0",
               count, out_valid, overflow);
    end
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      cycle();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL fl_stale got %0d exp 0", seen);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, i + 40, 0);
      cycle();
    end
    #2;
    rst_n = 1'b0;
    model_clear();
    drive(0, 0, 0);
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear got c%0d v%0d o%0d exp c0 v0 o0",
               count, out_valid, overflow);
    end
    cycle();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      cycle();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_stale got %0d exp 0", seen);
    end
  endtask

  task automatic test_random();
    int v;
    int sh;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 2000)) - 1000;
      else v = int'($signed(OW'($urandom)));
      if ($urandom_range(0, 3) == 0) sh = int'($urandom_range(0, OW - 1));
      else sh = int'($urandom_range(0, 7));
      drive($urandom_range(0, 9) < 7, v, sh);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 99) < 3);
      cycle();
      checks++;
      if (int'(count) !== fq.size() ||
          out_valid !== (fq.size() > 0)) begin
        errors++;
        $display("FAIL rnd_count[%0d] got c%0d v%0d exp c%0d",
                 i, count, out_valid, fq.size());
      end
      checks++;
      if (overflow !== ovf_m) begin
        errors++;
        $display("FAIL rnd_ovf[%0d] got %0d exp %0d",
                 i, overflow, ovf_m);
      end
      if (fq.size() > 0) begin
        checks++;
        if (int'($signed(out_data)) !== fq[0]) begin
          errors++;
          $display("FAIL rnd_data[%0d] got %0d exp %0d",
                   i, $signed(out_data), fq[0]);
        end
      end
    end
    flush = 1'b0;
    drive(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_overflow();
    test_back_to_back();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
